// File: rtl/fp_add_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
// Tag entries travel alongside each operation through the adder's latency.
package fp_add_pkg;

    localparam int FP_W                = 32;
    localparam int DEFAULT_ADD_LATENCY = 4;

    // Tag field is sized for up to 256 requesters; narrower indices are zero-extended.
    localparam int TAG_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/fp_add_tag_pipe.sv
// Fixed-depth shift register of owner tags, one stage per adder pipeline stage.
// The head entry lines up with the adder's result valid.
module fp_add_tag_pipe
    import fp_add_pkg::*;
#(
    parameter int DEPTH = DEFAULT_ADD_LATENCY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  tag_entry_t push,
    output tag_entry_t head,
    output logic       any_valid
);

    tag_entry_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign head = stages[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stages[i].valid;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder among NUM_REQ requesters,
// routing each sum back to its owner via a tag pipeline.
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = DEFAULT_ADD_LATENCY,
    parameter int TAG_W       = $clog2(NUM_REQ)
) (
    input  logic                    clkIn,
    input  logic                    rstIn,
    input  logic [NUM_REQ-1:0]      reqValidIn,
    input  logic [FP_W*NUM_REQ-1:0] reqDataAIn,
    input  logic [FP_W*NUM_REQ-1:0] reqDataBIn,
    output logic [NUM_REQ-1:0]      reqReadyOut,
    output logic [FP_W-1:0]         addDataAOut,
    output logic [FP_W-1:0]         addDataBOut,
    output logic                    addValidOut,
    input  logic [FP_W-1:0]         addDataIn,
    input  logic                    addValidIn,
    output logic [FP_W-1:0]         rspDataOut,
    output logic [NUM_REQ-1:0]      rspValidOut,
    output logic                    busyOut,
    output logic                    errorOut
);

    localparam int CNT_W = $clog2(ADD_LATENCY + 1);

    logic [TAG_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     drain_cnt;
    logic                 draining;
    logic                 grant_hit;
    logic [TAG_W-1:0]     grant_idx;
    logic                 accept;
    logic [TAG_MAX_W-1:0] issue_tag;
    tag_entry_t           push_entry;
    tag_entry_t           head_entry;
    logic                 tag_any_valid;
    int                   search_idx;

    assign draining = (drain_cnt != '0);

    // Search upward from rr_ptr, wrapping, for the first valid requester.
    always_comb begin
        grant_hit  = 1'b0;
        grant_idx  = '0;
        search_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_hit && reqValidIn[search_idx]) begin
                grant_hit = 1'b1;
                grant_idx = TAG_W'(search_idx);
            end
        end
    end

    assign accept      = rstIn && !draining && grant_hit;
    assign reqReadyOut = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            rr_ptr      <= '0;
            drain_cnt   <= CNT_W'(ADD_LATENCY);
            addValidOut <= 1'b0;
            addDataAOut <= '0;
            addDataBOut <= '0;
            issue_tag   <= '0;
        end else begin
            if (draining) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            addValidOut <= accept;
            if (accept) begin
                addDataAOut <= reqDataAIn[grant_idx*FP_W +: FP_W];
                addDataBOut <= reqDataBIn[grant_idx*FP_W +: FP_W];
                issue_tag   <= TAG_MAX_W'(grant_idx);
                rr_ptr      <= (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // The tag follows the registered issue, so the head meets addValidIn exactly.
    assign push_entry = {addValidOut, issue_tag};

    fp_add_tag_pipe #(
        .DEPTH (ADD_LATENCY)
    ) u_tag_pipe (
        .clk       (clkIn),
        .rst_n     (rstIn),
        .push      (push_entry),
        .head      (head_entry),
        .any_valid (tag_any_valid)
    );

    // Results arriving while draining belong to pre-reset work and are dropped.
    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            rspDataOut  <= '0;
            rspValidOut <= '0;
            errorOut    <= 1'b0;
        end else begin
            rspValidOut <= '0;
            if (!draining) begin
                if (head_entry.valid && addValidIn) begin
                    rspDataOut  <= addDataIn;
                    rspValidOut <= NUM_REQ'(1) << head_entry.tag;
                end
                if (head_entry.valid != addValidIn) begin
                    errorOut <= 1'b1;
                end
            end
        end
    end

    assign busyOut = !rstIn || draining || addValidOut || tag_any_valid;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural adder and a timing-level
// reference model checked every cycle.
module tb_fp_add_arbiter;

    localparam int N = 4;
    localparam int L = 4;

    typedef struct {
        int          tag;
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } op_t;

    typedef struct {
        int          cyc;
        logic [N-1:0] vec;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic            add_valid;
    logic [31:0]     add_sum;
    logic            add_sum_valid;
    logic [31:0]     rsp_data;
    logic [N-1:0]    rsp_valid;
    logic            busy;
    logic            error;
    logic            inject;

    fp_add_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L)) dut (
        .clkIn       (clk),
        .rstIn       (rst_n),
        .reqValidIn  (req_valid),
        .reqDataAIn  (req_a),
        .reqDataBIn  (req_b),
        .reqReadyOut (req_ready),
        .addDataAOut (add_a),
        .addDataBOut (add_b),
        .addValidOut (add_valid),
        .addDataIn   (add_sum),
        .addValidIn  (add_sum_valid),
        .rspDataOut  (rsp_data),
        .rspValidOut (rsp_valid),
        .busyOut     (busy),
        .errorOut    (error)
    );

    // Sum of two positive normal floats, truncating; exact for the operands used here.
    function automatic logic [31:0] fp_add_ref(input logic [31:0] x, input logic [31:0] y);
        logic [7:0]  ea, eb, et;
        logic [24:0] ma, mb, mt;
        int d;
        ea = x[30:23]; eb = y[30:23];
        ma = {2'b01, x[22:0]}; mb = {2'b01, y[22:0]};
        if (eb > ea) begin
            et = ea; ea = eb; eb = et;
            mt = ma; ma = mb; mb = mt;
        end
        d = int'(ea) - int'(eb);
        mb = (d > 24) ? '0 : (mb >> d);
        mt = ma + mb;
        if (mt[24]) begin
            mt = mt >> 1;
            ea = ea + 8'd1;
        end
        return {1'b0, ea, mt[22:0]};
    endfunction

    // Behavioural adder: fixed latency, never reset, so pre-reset work still emerges.
    logic        pv [L];
    logic [31:0] pa [L];
    logic [31:0] pb [L];
    always @(posedge clk) begin
        pv[0] <= (add_valid === 1'b1);
        pa[0] <= add_a;
        pb[0] <= add_b;
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign add_sum_valid = pv[L-1] | inject;
    assign add_sum       = fp_add_ref(pa[L-1], pb[L-1]);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state.
    int          cyc = 0;
    int          m_rr = 0;
    int          m_drain = L;
    logic        m_err = 1'b0;
    logic        m_av = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [N-1:0] m_rspv = '0;
    logic [31:0] m_rspd = '0;
    op_t         inflight[$];
    int          grant_log[$];
    rsp_t        rsp_log[$];
    logic [N-1:0] last_ready;

    task automatic step();
        logic [N-1:0] exp_ready;
        int   g;
        int   idx;
        logic hv;
        logic av_in;
        op_t  e;
        rsp_t r;
        #1;
        g = -1;
        exp_ready = '0;
        if (rst_n && m_drain == 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("ready", req_ready, exp_ready);
        last_ready = req_ready;
        av_in = add_sum_valid;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_rr = 0; m_drain = L; m_err = 1'b0; m_av = 1'b0;
            m_a = '0; m_b = '0; m_rspv = '0;
            inflight.delete();
        end else begin
            m_rspv = '0;
            hv = 1'b0;
            if (inflight.size() > 0 && inflight[0].due == cyc) begin
                hv = 1'b1;
                e = inflight.pop_front();
            end
            if (m_drain == 0) begin
                if (hv && av_in) begin
                    m_rspv = N'(1) << e.tag;
                    m_rspd = fp_add_ref(e.a, e.b);
                end
                if (hv != av_in) m_err = 1'b1;
            end else begin
                m_drain--;
            end
            m_av = (g >= 0);
            if (g >= 0) begin
                m_a = req_a[g*32 +: 32];
                m_b = req_b[g*32 +: 32];
                m_rr = (g + 1) % N;
                inflight.push_back('{tag: g, a: m_a, b: m_b, due: cyc + L + 1});
                grant_log.push_back(g);
            end
        end
        #1;
        check("add_valid", add_valid, m_av);
        check("add_a", add_a, m_a);
        check("add_b", add_b, m_b);
        check("rsp_valid", rsp_valid, m_rspv);
        if (m_rspv != '0) check("rsp_data", rsp_data, m_rspd);
        check("error", error, m_err);
        check("busy", busy, (!rst_n || m_drain != 0 || m_av || inflight.size() > 0));
        if (rsp_valid != '0) begin
            r.cyc = cyc; r.vec = rsp_valid; r.data = rsp_data;
            rsp_log.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]    = 1'b1;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    int g0, r0, acc, zero_cnt;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; inject = 1'b0;
        @(negedge clk);
        repeat (3) step();
        check("reset_busy", busy, 1);
        check("reset_error", error, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_add_valid", add_valid, 0);
        check("ref_half_plus_half", fp_add_ref(32'h3F000000, 32'h3F000000), 32'h3F800000);
        rst_n = 1'b1;
        repeat (L) step();

        // All requesters saturated for 8 cycles from rrPtr 0.
        for (int i = 0; i < N; i++) set_req(i, 32'h3F000000 + (32'(i) << 20), 32'h3F000000);
        g0 = grant_log.size(); r0 = rsp_log.size();
        repeat (8) step();
        req_valid = '0;
        repeat (L + 2) step();
        check("sat_grants", grant_log.size() - g0, 8);
        for (int k = 0; k < 8; k++) check("sat_order", grant_log[g0+k], k % 4);
        check("sat_rsp_count", rsp_log.size() - r0, 8);
        for (int k = 0; k < 8; k++) check("sat_rsp_owner", rsp_log[r0+k].vec, N'(1) << (k % 4));
        check("sat_first_sum", rsp_log[r0].data, 32'h3F800000);

        // Single request from requester 2: 1.0 + 2.0.
        set_req(2, 32'h3F800000, 32'h40000000);
        r0 = rsp_log.size();
        step();
        acc = cyc;
        req_valid = '0;
        check("single_add_valid", add_valid, 1);
        repeat (L + 2) step();
        check("single_rsp_count", rsp_log.size() - r0, 1);
        check("single_rsp_vec", rsp_log[r0].vec, 4'b0100);
        check("single_rsp_data", rsp_log[r0].data, 32'h40400000);
        check("single_latency", rsp_log[r0].cyc - acc, L + 1);

        // Move rrPtr to 2, then fairness between requesters 1 and 3.
        set_req(1, 32'h3F800000, 32'h3F800000);
        step();
        req_valid = '0;
        set_req(1, 32'h40000000, 32'h3F800000);
        set_req(3, 32'h40400000, 32'h3F800000);
        g0 = grant_log.size();
        repeat (4) begin
            step();
            check("fair_onehot", $countones(last_ready) <= 1, 1);
        end
        req_valid = '0;
        check("fair_g0", grant_log[g0], 3);
        check("fair_g1", grant_log[g0+1], 1);
        check("fair_g2", grant_log[g0+2], 3);
        check("fair_g3", grant_log[g0+3], 1);
        repeat (L + 2) step();

        // Back-to-back from requester 0.
        g0 = grant_log.size(); r0 = rsp_log.size();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 32'h3F800000 + (32'(k) << 20), 32'h3F800000);
            step();
            check("b2b_accept", grant_log.size() - g0, k + 1);
        end
        req_valid = '0;
        repeat (L + 1) step();
        check("b2b_rsp_count", rsp_log.size() - r0, 4);
        for (int k = 0; k < 4; k++) begin
            check("b2b_rsp_vec", rsp_log[r0+k].vec, 4'b0001);
            check("b2b_rsp_cyc", rsp_log[r0+k].cyc - rsp_log[r0].cyc, k);
        end
        check("b2b_busy_low", busy, 0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) set_req(i, 32'h3F800000, 32'h40000000);
        repeat (3) step();
        r0 = rsp_log.size();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        zero_cnt = 0;
        repeat (L) begin
            step();
            if (last_ready == '0) zero_cnt++;
        end
        check("rst_drain_cycles", zero_cnt, L);
        step();
        check("rst_grant_resumes", last_ready != '0, 1);
        check("rst_no_stale_rsp", rsp_log.size() - r0, 0);
        check("rst_error_clear", error, 0);
        req_valid = '0;
        repeat (L + 2) step();

        // Spurious adder valid with an empty tag head.
        r0 = rsp_log.size();
        inject = 1'b1;
        step();
        inject = 1'b0;
        check("inj_error", error, 1);
        check("inj_no_rsp", rsp_valid, 0);
        step();
        check("inj_sticky", error, 1);
        set_req(3, 32'h3F800000, 32'h3F800000);
        step();
        req_valid = '0;
        repeat (L + 1) step();
        check("inj_rsp_count", rsp_log.size() - r0, 1);
        check("inj_later_vec", rsp_log[r0].vec, 4'b1000);
        check("inj_later_data", rsp_log[r0].data, 32'h40000000);
        check("inj_still_sticky", error, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
